uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmitter that replaces the fixed 8N1 transmit path.
- Adds an internal baud generator; the externally supplied baud clock is no longer needed.
- Configurable data width, parity mode and stop-bit count.
- Provides a ready/start/done handshake so the pattern bench or an upstream FIFO can stream back-to-back frames.
- Sits between the byte source and the RS-232 TXD pad.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DATA_BITS, 8, payload width, legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, legal values 1 or 2.
- clk  in  1  system clock; the only clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_tx_start  in  1  frame request, sampled on rising clk.
- i_data  in  DATA_BITS  payload, captured only on the accept cycle.
- o_tx_ready  out  1  high when idle and able to accept.
- o_rs232_txd  out  1  serial line, registered, idle high.
- o_baudrate_tx_clk_en  out  1  one-cycle pulse at the end of each bit period while a frame is active.
- o_tx_done  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Derived constants:
  - BAUD_DIV = (CLK_FREQ + BAUD/2) / BAUD. This is 434 at the defaults.
  - P = 1 when PARITY != 0, else 0.
  - FRAME_BITS = 1 + DATA_BITS + P + STOP_BITS.
  - FRAME_LEN = FRAME_BITS × BAUD_DIV cycles.
- Elaboration error if DATA_BITS is outside 5..9, PARITY > 2, STOP_BITS is not 1 or 2, or BAUD_DIV < 2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when i_tx_start = 1. On the same edge the block latches i_data into the shift register and clears the baud counter.
  - START → DATA after one bit period.
  - DATA shifts LSB first. After DATA_BITS bit periods it moves to PARITY if P = 1, otherwise to STOP.
  - PARITY → STOP after one bit period. The parity bit is the XOR of the latched data (even), or its inverse (odd).
  - STOP holds the line high for STOP_BITS bit periods, then → IDLE.
- Baud counter runs 0..BAUD_DIV-1 in every non-IDLE state and wraps. o_baudrate_tx_clk_en = 1 when the counter = BAUD_DIV-1. Every state transition and bit-index advance happens on that pulse.
- A bit index counts data bits and stop bits. Its width is clog2(9) = 4.
- i_tx_start while not in IDLE is ignored: no queueing, no error flag. i_data changes after the accept edge have no effect on the frame.
- o_tx_ready = (state == IDLE), combinational from the state register.

## Timing
- Reset values: o_rs232_txd = 1, o_tx_ready = 1, o_tx_done = 0, o_baudrate_tx_clk_en = 0, state IDLE, counters 0.
- Reset asserted mid-frame: the line returns high asynchronously and the frame is abandoned. No done pulse, either during reset or after release.
- Accept edge E0 is the rising clk edge with i_tx_start = 1 and o_tx_ready = 1. After E0:
  - o_rs232_txd = 0 and o_tx_ready = 0.
  - Bit n of the frame drives the line for cycles E0+n·BAUD_DIV .. E0+(n+1)·BAUD_DIV-1.
- o_tx_done is high for exactly the one cycle following edge E0+FRAME_LEN. In that cycle:
  - state is IDLE;
  - o_tx_ready = 1;
  - o_rs232_txd = 1.
- Back-to-back frames: start held high in the done cycle is accepted at that edge. The next start bit follows with zero idle cycles.
- Latency from i_tx_start to line low is 1 clk.

## Structure
- Package uart_pkg holds:
  - the PARITY_NONE / PARITY_ODD / PARITY_EVEN constants;
  - the tx state encoding typedef;
  - a function baud_div(clk_freq, baud) returning the rounded divisor.
  The future receiver reuses all three.
- One sub-module, uart_baud_gen. Parameter DIV; inputs clk, rst_n, clear, run; output tick. It implements the wrapping counter and the end-of-bit pulse and is shared with the receiver.
- The FSM, shift register, parity and bit index stay in uart_tx_frame.

## Test plan
- Defaults (8N1, BAUD_DIV 434), start with i_data = 8'h55:
  - line sequence 0,1,0,1,0,1,0,1,0,1, each bit 434 cycles;
  - o_tx_done exactly 4340 cycles after accept;
  - exactly 10 o_baudrate_tx_clk_en pulses.
- PARITY = 2, STOP_BITS = 2, i_data = 8'hA7 (five 1s):
  - parity bit 1, followed by two stop bits;
  - done after 12 × 434 = 5208 cycles.
- PARITY = 1, DATA_BITS = 7, i_data = 7'h00:
  - parity bit 1;
  - frame length 10 bit periods.
- Pulse start again at mid-frame with i_data = 8'hFF:
  - ignored, and the current frame is unchanged;
  - start held high through done, with i_data = 8'h3C:
    - second start bit begins the cycle after done;
    - no idle gap between the two frames.
- Assert rst_n low during DATA bit 3 for 2 cycles:
  - txd goes high immediately and ready = 1 after release;
  - no done pulse;
  - the next start sends a complete, correct frame.
- Random regression, 200 payloads with 5000-cycle gaps at the defaults:
  - a bench-side UART decoder reproduces every byte;
  - zero parity or framing errors.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, tx state encoding and baud divisor helper
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // Divisor rounded to the nearest integer rather than truncated.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - wrapping bit-period counter with end-of-bit tick
//
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   clear - restart the bit period from zero
//   run   - count while high; held at zero while low
//   tick  - high for the last cycle of each bit period while running
module uart_baud_gen #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !run || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmitter with internal baud generator
//
// Ports:
//   clk                  - system clock
//   rst_n                - asynchronous active-low reset
//   i_tx_start           - frame request, accepted only while ready
//   i_data               - payload, captured on the accept edge
//   o_tx_ready           - idle and able to accept a frame
//   o_rs232_txd          - registered serial line, idle high
//   o_baudrate_tx_clk_en - end-of-bit pulse while a frame is active
//   o_tx_done            - one-cycle pulse after the last stop bit
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx_ready,
    output logic                 o_rs232_txd,
    output logic                 o_baudrate_tx_clk_en,
    output logic                 o_tx_done
);

    localparam int         BAUD_DIV   = baud_div(CLK_FREQ, BAUD);
    localparam bit         HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_tx_frame: baud divisor below 2");
    end

    tx_state_t            state;
    tx_state_t            next_state;
    logic                 accept;
    logic                 tick;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_bit;
    logic [3:0]           bit_idx;

    uart_baud_gen #(
        .DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .run   (!o_tx_ready),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TX_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            TX_IDLE:   if (i_tx_start) next_state = TX_START;
            TX_START:  if (tick) next_state = TX_DATA;
            TX_DATA:   if (tick && bit_idx == LAST_DATA)
                           next_state = HAS_PARITY ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tick) next_state = TX_STOP;
            TX_STOP:   if (tick && bit_idx == LAST_STOP) next_state = TX_IDLE;
            default:   next_state = TX_IDLE;
        endcase
    end

    always_comb begin
        o_tx_ready           = (state == TX_IDLE);
        accept               = i_tx_start && (state == TX_IDLE);
        o_baudrate_tx_clk_en = tick;
    end

    // The line register is loaded with the value of the bit that the next
    // state will drive, so each bit appears exactly on its bit-period edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            parity_bit  <= 1'b0;
            bit_idx     <= '0;
            o_rs232_txd <= 1'b1;
            o_tx_done   <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            if (accept) begin
                shreg       <= i_data;
                parity_bit  <= (^i_data) ^ (PARITY == PARITY_ODD);
                bit_idx     <= '0;
                o_rs232_txd <= 1'b0;
            end else if (tick) begin
                case (state)
                    TX_START: begin
                        o_rs232_txd <= shreg[0];
                    end
                    TX_DATA: begin
                        if (bit_idx == LAST_DATA) begin
                            bit_idx     <= '0;
                            o_rs232_txd <= HAS_PARITY ? parity_bit : 1'b1;
                        end else begin
                            bit_idx     <= bit_idx + 1'b1;
                            shreg       <= shreg >> 1;
                            o_rs232_txd <= shreg[1];
                        end
                    end
                    TX_PARITY: begin
                        o_rs232_txd <= 1'b1;
                    end
                    TX_STOP: begin
                        o_rs232_txd <= 1'b1;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx   <= '0;
                            o_tx_done <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    default: begin
                        o_rs232_txd <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
